// File: rtl/cmd_reply_encoder_pkg.sv
// Shared reply-format definitions for the port-1 command responder.
// Status word layout is also used by the port-1/2 UDP transmitters.
package cmd_reply_encoder_pkg;

   localparam int unsigned N_SRC_DEF   = 3;
   localparam int unsigned REPLY_BYTES = 9;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CODE_ACK  = 8'h06;
   localparam logic [7:0] CODE_NAK  = 8'h15;
   localparam logic [7:0] CODE_ERR  = 8'hEE;

   localparam int unsigned STAT_W       = 96;
   localparam int unsigned STAT_LEN_LSB = 0;
   localparam int unsigned STAT_IP_LSB  = 16;
   localparam int unsigned STAT_MAC_LSB = 48;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_STATUS
   } tx_state_t;

   function automatic logic [7:0] reply_code(
      input logic ack,
      input logic nak,
      input logic err
   );
      logic [7:0] c;
      c = CODE_ACK;
      if (ack) c = CODE_ACK;
      if (nak) c = CODE_NAK;
      if (err) c = CODE_ERR;
      return c;
   endfunction

   function automatic logic [STAT_W-1:0] status_word(
      input logic [47:0] mac,
      input logic [31:0] ip,
      input logic [15:0] len
   );
      logic [STAT_W-1:0] w;
      w = '0;
      w[STAT_MAC_LSB +: 48] = mac;
      w[STAT_IP_LSB  +: 32] = ip;
      w[STAT_LEN_LSB +: 16] = len;
      return w;
   endfunction

endpackage

// File: rtl/cmd_reply_encoder_slot.sv
// One response slot: captures a decoder's ack/nak/err with its command
// word and holds it until the arbiter takes it; later events overrun.
module reply_pending_slot
   import cmd_reply_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ack,
   input  logic        nak,
   input  logic        err,
   input  logic [31:0] data_in,
   input  logic        clear,
   output logic        pending,
   output logic [7:0]  code,
   output logic [31:0] data,
   output logic        overrun
);

   logic        pending_q, pending_d;
   logic [7:0]  code_q, code_d;
   logic [31:0] data_q, data_d;
   logic        evt;
   logic        accept;

   always_comb begin
      evt       = ack | nak | err;
      // a slot being drained this cycle is free for a new event
      accept    = evt && (!pending_q || clear);
      overrun   = evt && pending_q && !clear;
      pending_d = pending_q;
      code_d    = code_q;
      data_d    = data_q;
      if (clear) pending_d = 1'b0;
      if (accept) begin
         pending_d = 1'b1;
         code_d    = reply_code(ack, nak, err);
         data_d    = data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= 1'b0;
         code_q    <= '0;
         data_q    <= '0;
      end else begin
         pending_q <= pending_d;
         code_q    <= code_d;
         data_q    <= data_d;
      end
   end

   assign pending = pending_q;
   assign code    = code_q;
   assign data    = data_q;

endmodule

// File: rtl/cmd_reply_encoder.sv
// Port-1 command responder: arbitrates pending decoder responses and
// writes fixed 9-byte UDP replies plus one status word per packet.
module cmd_reply_encoder
   import cmd_reply_encoder_pkg::*;
#(
   parameter int unsigned N_SRC = N_SRC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [47:0]       client_mac,
   input  logic [31:0]       client_ip,
   input  logic [31:0]       received_data,
   input  logic [N_SRC-1:0]  resp_ack,
   input  logic [N_SRC-1:0]  resp_nak,
   input  logic [N_SRC-1:0]  resp_err,
   output logic [7:0]        tx_fifo_data,
   output logic              tx_fifo_data_write,
   input  logic              tx_fifo_data_full,
   output logic [95:0]       tx_fifo_status,
   output logic              tx_fifo_status_write,
   input  logic              tx_fifo_status_full,
   output logic              busy,
   output logic [7:0]        dropped_count
);

   localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] clr;
   logic [N_SRC-1:0] ovr;
   logic [7:0]       slot_code [N_SRC];
   logic [31:0]      slot_data [N_SRC];

   for (genvar g = 0; g < N_SRC; g++) begin : g_slot
      reply_pending_slot u_slot (
         .clk     (clk),
         .reset   (reset),
         .ack     (resp_ack[g]),
         .nak     (resp_nak[g]),
         .err     (resp_err[g]),
         .data_in (received_data),
         .clear   (clr[g]),
         .pending (pend[g]),
         .code    (slot_code[g]),
         .data    (slot_data[g]),
         .overrun (ovr[g])
      );
   end

   tx_state_t   state_q, state_d;
   logic [3:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  seq_q, seq_d;
   logic [7:0]  src_q, src_d;
   logic [7:0]  code_q, code_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  dropped_q, dropped_d;

   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic             start;
   logic [7:0]       cur_byte;
   logic [7:0]       csum;
   logic [8:0]       drop_sum;

   // lowest pending index wins
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel_found = 1'b1;
            sel_idx   = i[IDX_W-1:0];
         end
      end
      start = (state_q == ST_IDLE) && sel_found && !tx_fifo_status_full;
      clr   = '0;
      clr[sel_idx] = start;
   end

   always_comb begin
      csum = SYNC_BYTE ^ src_q ^ code_q ^ seq_q ^ data_q[31:24]
           ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
      unique case (byte_idx_q)
         4'd0:    cur_byte = SYNC_BYTE;
         4'd1:    cur_byte = src_q;
         4'd2:    cur_byte = code_q;
         4'd3:    cur_byte = seq_q;
         4'd4:    cur_byte = data_q[31:24];
         4'd5:    cur_byte = data_q[23:16];
         4'd6:    cur_byte = data_q[15:8];
         4'd7:    cur_byte = data_q[7:0];
         4'd8:    cur_byte = csum;
         default: cur_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d              = state_q;
      byte_idx_d           = byte_idx_q;
      seq_d                = seq_q;
      src_d                = src_q;
      code_d               = code_q;
      data_d               = data_q;
      tx_fifo_data         = 8'h00;
      tx_fifo_data_write   = 1'b0;
      tx_fifo_status       = '0;
      tx_fifo_status_write = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SEND;
               byte_idx_d = '0;
               src_d      = 8'(sel_idx);
               code_d     = slot_code[sel_idx];
               data_d     = slot_data[sel_idx];
            end
         end
         ST_SEND: begin
            tx_fifo_data       = cur_byte;
            tx_fifo_data_write = !tx_fifo_data_full;
            if (!tx_fifo_data_full) begin
               if (byte_idx_q == 4'(REPLY_BYTES - 1)) state_d = ST_STATUS;
               else byte_idx_d = byte_idx_q + 4'd1;
            end
         end
         ST_STATUS: begin
            tx_fifo_status       = status_word(client_mac, client_ip,
                                               16'(REPLY_BYTES));
            tx_fifo_status_write = 1'b1;
            seq_d                = seq_q + 8'd1;
            state_d              = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      drop_sum = {1'b0, dropped_q};
      for (int i = 0; i < N_SRC; i++) drop_sum = drop_sum + 9'(ovr[i]);
      dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= '0;
         seq_q      <= '0;
         src_q      <= '0;
         code_q     <= '0;
         data_q     <= '0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         seq_q      <= seq_d;
         src_q      <= src_d;
         code_q     <= code_d;
         data_q     <= data_d;
         dropped_q  <= dropped_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign dropped_count = dropped_q;

endmodule

// File: tb/tb_cmd_reply_encoder.sv
// Directed bench for cmd_reply_encoder: packet bytes, latency, arbitration,
// overrun, backpressure, seq wrap and mid-packet reset.
module tb_cmd_reply_encoder;

   localparam logic [47:0] MAC = 48'h0200_DEAD_BEEF;
   localparam logic [31:0] IP  = 32'hC0A8_0164;

   logic        clk = 1'b0;
   logic        reset;
   logic [47:0] client_mac;
   logic [31:0] client_ip;
   logic [31:0] received_data;
   logic [2:0]  resp_ack, resp_nak, resp_err;
   logic [7:0]  tx_fifo_data;
   logic        tx_fifo_data_write;
   logic        tx_fifo_data_full;
   logic [95:0] tx_fifo_status;
   logic        tx_fifo_status_write;
   logic        tx_fifo_status_full;
   logic        busy;
   logic [7:0]  dropped_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] exp_seq = 8'h00;

   logic [7:0]  byte_q[$];
   int          byte_cyc_q[$];
   logic [95:0] stat_q[$];
   int          stat_cyc_q[$];

   cmd_reply_encoder dut (
      .clk                  (clk),
      .reset                (reset),
      .client_mac           (client_mac),
      .client_ip            (client_ip),
      .received_data        (received_data),
      .resp_ack             (resp_ack),
      .resp_nak             (resp_nak),
      .resp_err             (resp_err),
      .tx_fifo_data         (tx_fifo_data),
      .tx_fifo_data_write   (tx_fifo_data_write),
      .tx_fifo_data_full    (tx_fifo_data_full),
      .tx_fifo_status       (tx_fifo_status),
      .tx_fifo_status_write (tx_fifo_status_write),
      .tx_fifo_status_full  (tx_fifo_status_full),
      .busy                 (busy),
      .dropped_count        (dropped_count)
   );

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_fifo_data_write) begin
         byte_q.push_back(tx_fifo_data);
         byte_cyc_q.push_back(cyc);
      end
      if (tx_fifo_status_write) begin
         stat_q.push_back(tx_fifo_status);
         stat_cyc_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [95:0] obs,
                        input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [2:0] a, input logic [2:0] n,
                        input logic [2:0] e, input logic [31:0] d);
      resp_ack      = a;
      resp_nak      = n;
      resp_err      = e;
      received_data = d;
      tick();
      resp_ack = '0;
      resp_nak = '0;
      resp_err = '0;
   endtask

   task automatic chk_pkt(input int src, input logic [7:0] code,
                          input logic [31:0] d, input int t0);
      logic [7:0] exp [9];
      logic [7:0] ck;
      logic [7:0] b;
      int bc;
      int n;
      exp[0] = 8'hA5;
      exp[1] = src[7:0];
      exp[2] = code;
      exp[3] = exp_seq;
      exp[4] = d[31:24];
      exp[5] = d[23:16];
      exp[6] = d[15:8];
      exp[7] = d[7:0];
      ck = 8'h00;
      for (int k = 0; k < 8; k++) ck = ck ^ exp[k];
      exp[8] = ck;
      n = 0;
      while ((byte_q.size() < 9 || stat_q.size() < 1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("pkt_ready", 96'(byte_q.size() >= 9 && stat_q.size() >= 1), 96'd1);
      if (byte_q.size() >= 9 && stat_q.size() >= 1) begin
         for (int k = 0; k < 9; k++) begin
            b  = byte_q.pop_front();
            bc = byte_cyc_q.pop_front();
            check($sformatf("src%0d_seq%0h_byte%0d", src, exp_seq, k), 96'(b),
                  96'(exp[k]));
            if (t0 >= 0)
               check($sformatf("lat_byte%0d", k), 96'(bc), 96'(t0 + 2 + k));
         end
         bc = stat_cyc_q.pop_front();
         check("status_word", stat_q.pop_front(), {MAC, IP, 16'd9});
         if (t0 >= 0) check("lat_status", 96'(bc), 96'(t0 + 11));
      end
      exp_seq = exp_seq + 8'd1;
   endtask

   initial begin
      int t0;
      int n;
      reset               = 1'b1;
      client_mac          = MAC;
      client_ip           = IP;
      received_data       = '0;
      resp_ack            = '0;
      resp_nak            = '0;
      resp_err            = '0;
      tx_fifo_data_full   = 1'b0;
      tx_fifo_status_full = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_data", 96'(tx_fifo_data), 96'd0);
      check("rst_dwr", 96'(tx_fifo_data_write), 96'd0);
      check("rst_status", tx_fifo_status, 96'd0);
      check("rst_swr", 96'(tx_fifo_status_write), 96'd0);
      check("rst_busy", 96'(busy), 96'd0);
      check("rst_drop", 96'(dropped_count), 96'd0);

      // single ack on src 1, checksum A5^01^06^00^12^34^56^78 = AA
      t0 = cyc;
      pulse(3'b010, 3'b000, 3'b000, 32'h1234_5678);
      check("busy_before_start", 96'(busy), 96'd0);
      chk_pkt(1, 8'h06, 32'h1234_5678, t0);

      // same-cycle ack[0] and err[2]
      pulse(3'b001, 3'b000, 3'b100, 32'hCAFE_F00D);
      chk_pkt(0, 8'h06, 32'hCAFE_F00D, -1);
      chk_pkt(2, 8'hEE, 32'hCAFE_F00D, -1);
      check("drop_after_pair", 96'(dropped_count), 96'd0);

      // ack and nak on one source: nak wins
      pulse(3'b001, 3'b001, 3'b000, 32'h0BAD_CAFE);
      chk_pkt(0, 8'h15, 32'h0BAD_CAFE, -1);
      check("drop_after_prio", 96'(dropped_count), 96'd0);

      // overrun on src 0 while src 1 is in flight
      pulse(3'b010, 3'b000, 3'b000, 32'h1111_1111);
      pulse(3'b001, 3'b000, 3'b000, 32'hAAAA_0001);
      pulse(3'b001, 3'b000, 3'b000, 32'hBBBB_0002);
      check("drop_overrun", 96'(dropped_count), 96'd1);
      chk_pkt(1, 8'h06, 32'h1111_1111, -1);
      chk_pkt(0, 8'h06, 32'hAAAA_0001, -1);

      // data FIFO full for 5 cycles mid-packet
      pulse(3'b100, 3'b000, 3'b000, 32'h5566_7788);
      n = 0;
      while (byte_q.size() < 3 && n < 50) begin
         tick();
         n++;
      end
      tx_fifo_data_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("stall_wr%0d", i), 96'(tx_fifo_data_write), 96'd0);
         tick();
      end
      tx_fifo_data_full = 1'b0;
      chk_pkt(2, 8'h06, 32'h5566_7788, -1);

      // status FIFO full at request: nothing starts
      tx_fifo_status_full = 1'b1;
      pulse(3'b010, 3'b000, 3'b000, 32'h0F0F_F0F0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("sfull_wr%0d", i), 96'(tx_fifo_data_write), 96'd0);
         check($sformatf("sfull_busy%0d", i), 96'(busy), 96'd0);
         tick();
      end
      tx_fifo_status_full = 1'b0;
      chk_pkt(1, 8'h06, 32'h0F0F_F0F0, -1);
      check("drop_before_wrap", 96'(dropped_count), 96'd1);

      // seq wrap: 256 replies after reset, then the 257th carries seq 00
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_seq = 8'h00;
      for (int i = 0; i < 256; i++) begin
         pulse(3'b010, 3'b000, 3'b000, 32'(i) ^ 32'h3C00_00C3);
         chk_pkt(1, 8'h06, 32'(i) ^ 32'h3C00_00C3, -1);
      end
      pulse(3'b001, 3'b000, 3'b000, 32'h2570_0257);
      chk_pkt(0, 8'h06, 32'h2570_0257, -1);

      // reset while byte 4 is on the bus
      pulse(3'b001, 3'b000, 3'b000, 32'hDEAD_0004);
      n = 0;
      while (byte_q.size() < 4 && n < 50) begin
         tick();
         n++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("mrst_dwr", 96'(tx_fifo_data_write), 96'd0);
      check("mrst_swr", 96'(tx_fifo_status_write), 96'd0);
      check("mrst_busy", 96'(busy), 96'd0);
      check("mrst_data", 96'(tx_fifo_data), 96'd0);
      byte_q.delete();
      byte_cyc_q.delete();
      stat_q.delete();
      stat_cyc_q.delete();
      for (int i = 0; i < 15; i++) tick();
      check("mrst_no_bytes", 96'(byte_q.size()), 96'd0);
      check("mrst_no_status", 96'(stat_q.size()), 96'd0);
      exp_seq = 8'h00;
      t0 = cyc;
      pulse(3'b100, 3'b000, 3'b000, 32'h0000_00FF);
      chk_pkt(2, 8'h06, 32'h0000_00FF, t0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
